// File: rtl/router_pkg.sv
// Shared definitions for the router packet source: field widths, the state
// encoding and the header pack/unpack helpers used by the router decode.
package router_pkg;

   localparam int ADDR_W = 2;
   localparam int LEN_W  = 6;
   localparam int DATA_W = 8;

   localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_HEADER,
      ST_PAYLOAD,
      ST_PARITY,
      ST_GAP
   } tx_state_t;

   function automatic logic [DATA_W-1:0] pack_hdr(input logic [LEN_W-1:0]  len,
                                                  input logic [ADDR_W-1:0] addr);
      return {len, addr};
   endfunction

   function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
      return hdr[DATA_W-1:ADDR_W];
   endfunction

   function automatic logic [ADDR_W-1:0] hdr_addr(input logic [DATA_W-1:0] hdr);
      return hdr[ADDR_W-1:0];
   endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Request, payload-load and router-side signals of the packet source.
// The slave modport is the packet source itself; master is its environment.
interface router_pkt_tx_if;
   import router_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [LEN_W-1:0]  req_len;
   logic              ld_valid;
   logic [DATA_W-1:0] ld_data;
   logic              ld_ready;
   logic              busy;
   logic              pkt_valid;
   logic [DATA_W-1:0] data_out;
   logic              tx_active;
   logic              pkt_done;
   logic              req_err;

   modport master (
      output req_valid, req_addr, req_len, ld_valid, ld_data, busy,
      input  req_ready, ld_ready, pkt_valid, data_out, tx_active, pkt_done, req_err
   );

   modport slave (
      input  req_valid, req_addr, req_len, ld_valid, ld_data, busy,
      output req_ready, ld_ready, pkt_valid, data_out, tx_active, pkt_done, req_err
   );

endinterface

// File: rtl/router_tx_buf.sv
// Payload buffer: register array with one synchronous write port and one
// asynchronous read port.
module router_tx_buf
   import router_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source: buffers a request's payload, then serializes header,
// payload and parity onto the router input port under busy back-pressure.
module router_pkt_tx
   import router_pkg::*;
#(
   parameter int MAX_LEN = 63,
   parameter int IFG     = 2
) (
   input  logic           clock,
   input  logic           reset,
   router_pkt_tx_if.slave bus
);

   localparam int DEPTH = MAX_LEN + 1;
   localparam int AW    = $clog2(DEPTH);
   localparam int GAP_W = $clog2(IFG + 2);

   tx_state_t         state_q, state_d;
   logic [DATA_W-1:0] hdr_q, hdr_d;
   logic [DATA_W-1:0] parity_q, parity_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [LEN_W-1:0]  idx_q, idx_d;
   logic [GAP_W-1:0]  gap_q, gap_d;

   logic              req_ready_q, req_ready_d;
   logic              ld_ready_q, ld_ready_d;
   logic              pkt_valid_q, pkt_valid_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              tx_active_q, tx_active_d;
   logic              pkt_done_q, pkt_done_d;
   logic              req_err_q, req_err_d;

   logic              buf_we;
   logic [DATA_W-1:0] rd_data;
   logic [LEN_W-1:0]  last_idx;
   logic              req_fire, ld_fire, consume;

   router_tx_buf #(.DEPTH(DEPTH)) u_buf (
      .clk_i   (clock),
      .we_i    (buf_we),
      .waddr_i (AW'(cnt_q)),
      .wdata_i (bus.ld_data),
      .raddr_i (AW'(idx_d)),
      .rdata_o (rd_data)
   );

   always_comb begin
      state_d    = state_q;
      hdr_d      = hdr_q;
      parity_d   = parity_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      gap_d      = gap_q;
      buf_we     = 1'b0;
      req_err_d  = 1'b0;
      pkt_done_d = 1'b0;
      last_idx   = hdr_len(hdr_q) - LEN_W'(1);
      req_fire   = bus.req_valid & req_ready_q;
      ld_fire    = bus.ld_valid & ld_ready_q;
      consume    = ~bus.busy;

      case (state_q)
         ST_IDLE: begin
            if (req_fire) begin
               if (bus.req_addr == ADDR_INVALID || bus.req_len == '0) begin
                  req_err_d = 1'b1;
               end else begin
                  state_d  = ST_LOAD;
                  hdr_d    = pack_hdr(bus.req_len, bus.req_addr);
                  parity_d = pack_hdr(bus.req_len, bus.req_addr);
                  cnt_d    = '0;
               end
            end
         end
         ST_LOAD: begin
            if (ld_fire) begin
               buf_we   = 1'b1;
               parity_d = parity_q ^ bus.ld_data;
               if (cnt_q == last_idx) begin
                  state_d = ST_HEADER;
               end else begin
                  cnt_d = cnt_q + LEN_W'(1);
               end
            end
         end
         ST_HEADER: begin
            if (consume) begin
               idx_d   = '0;
               state_d = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (consume) begin
               if (idx_q == last_idx) begin
                  state_d = ST_PARITY;
               end else begin
                  idx_d = idx_q + LEN_W'(1);
               end
            end
         end
         ST_PARITY: begin
            if (consume) begin
               pkt_done_d = 1'b1;
               gap_d      = '0;
               state_d    = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_W'(IFG)) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are registered, so they are decoded from the next state.
      req_ready_d = (state_d == ST_IDLE);
      ld_ready_d  = (state_d == ST_LOAD);
      pkt_valid_d = (state_d == ST_HEADER) || (state_d == ST_PAYLOAD);
      tx_active_d = (state_d != ST_IDLE);
      case (state_d)
         ST_HEADER:  data_out_d = hdr_d;
         ST_PAYLOAD: data_out_d = rd_data;
         ST_PARITY:  data_out_d = parity_d;
         default:    data_out_d = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         gap_q       <= '0;
         req_ready_q <= 1'b0;
         ld_ready_q  <= 1'b0;
         pkt_valid_q <= 1'b0;
         data_out_q  <= '0;
         tx_active_q <= 1'b0;
         pkt_done_q  <= 1'b0;
         req_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         gap_q       <= gap_d;
         req_ready_q <= req_ready_d;
         ld_ready_q  <= ld_ready_d;
         pkt_valid_q <= pkt_valid_d;
         data_out_q  <= data_out_d;
         tx_active_q <= tx_active_d;
         pkt_done_q  <= pkt_done_d;
         req_err_q   <= req_err_d;
      end
      hdr_q    <= hdr_d;
      parity_q <= parity_d;
   end

   assign bus.req_ready = req_ready_q;
   assign bus.ld_ready  = ld_ready_q;
   assign bus.pkt_valid = pkt_valid_q;
   assign bus.data_out  = data_out_q;
   assign bus.tx_active = tx_active_q;
   assign bus.pkt_done  = pkt_done_q;
   assign bus.req_err   = req_err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Randomized bench for router_pkt_tx: a packet-level reference model is
// checked against every output each cycle, plus directed literal checks.
module tb_router_pkt_tx;

   localparam int IFG = 2;

   logic clk;
   logic rst;
   router_pkt_tx_if bus ();

   router_pkt_tx #(.MAX_LEN(63), .IFG(IFG)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- cycle counter and busy driver ----------------
   int cyc = 0;
   int hold_until = 0;
   int busy_pct = 0;
   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      #1;
      bus.busy = (cyc < hold_until) || ($urandom_range(99) < busy_pct);
   end

   // ---------------- reference model ----------------
   // mode: 0 idle, 1 loading, 2 sending stream[pos], 3 inter-frame gap
   int         m_mode = 0, m_pos = 0, m_len = 0, m_gap = 0;
   logic [7:0] m_stream[$];
   logic       e_req_ready, e_ld_ready, e_pv, e_act, e_done, e_err;
   logic [7:0] e_data;

   always @(posedge clk) begin
      if (rst) begin
         m_mode = 0; m_pos = 0;
         e_req_ready = 0; e_ld_ready = 0; e_pv = 0; e_data = 0;
         e_act = 0; e_done = 0; e_err = 0;
      end else begin
         e_done = 0; e_err = 0;
         case (m_mode)
            0: if (bus.req_valid && e_req_ready) begin
                  if (bus.req_addr == 2'b11 || bus.req_len == 0) e_err = 1;
                  else begin
                     m_len = int'(bus.req_len);
                     m_stream.delete();
                     m_stream.push_back({bus.req_len, bus.req_addr});
                     m_mode = 1;
                  end
               end
            1: if (bus.ld_valid && e_ld_ready) begin
                  m_stream.push_back(bus.ld_data);
                  if (m_stream.size() == m_len + 1) begin
                     logic [7:0] p;
                     p = 8'h00;
                     foreach (m_stream[k]) p ^= m_stream[k];
                     m_stream.push_back(p);
                     m_pos = 0;
                     m_mode = 2;
                  end
               end
            2: if (!bus.busy) begin
                  m_pos++;
                  if (m_pos == m_len + 2) begin
                     e_done = 1; m_gap = 0; m_mode = 3;
                  end
               end
            default: begin
               m_gap++;
               if (m_gap == IFG + 1) m_mode = 0;
            end
         endcase
         e_req_ready = (m_mode == 0);
         e_ld_ready  = (m_mode == 1);
         e_act       = (m_mode != 0);
         e_pv        = (m_mode == 2) && (m_pos <= m_len);
         e_data      = (m_mode == 2) ? m_stream[m_pos] : 8'h00;
      end
   end

   // ---------------- per-cycle compare ----------------
   int run = 0, last_run = 0, done_cnt = 0, err_cnt = 0;
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         chk("req_ready", bus.req_ready, e_req_ready);
         chk("ld_ready",  bus.ld_ready,  e_ld_ready);
         chk("pkt_valid", bus.pkt_valid, e_pv);
         chk("data_out",  bus.data_out,  e_data);
         chk("tx_active", bus.tx_active, e_act);
         chk("pkt_done",  bus.pkt_done,  e_done);
         chk("req_err",   bus.req_err,   e_err);
         if (bus.pkt_valid) run++;
         else begin
            if (run > 0) last_run = run;
            run = 0;
         end
         if (bus.pkt_done) done_cnt++;
         if (bus.req_err) err_cnt++;
      end
   end

   // ---------------- consumed-byte monitor ----------------
   logic [7:0] got[$];
   logic [7:0] got_par;
   bit         last_v = 0;
   always @(posedge clk) begin
      if (rst) begin
         got.delete(); last_v = 0;
      end else if (!bus.busy) begin
         if (bus.pkt_valid) begin
            got.push_back(bus.data_out); last_v = 1;
         end else if (last_v) begin
            got_par = bus.data_out; last_v = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [7:0] pay[64];

   task automatic send_req(input logic [1:0] a, input logic [5:0] n);
      bit ok = 0;
      @(negedge clk);
      bus.req_valid = 1; bus.req_addr = a; bus.req_len = n;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(posedge clk);
         if (bus.req_ready) ok = 1;
      end
      if (!ok) chk("req_accept_timeout", 0, 1);
      @(negedge clk);
      bus.req_valid = 0;
   endtask

   task automatic load(input int n, input int stall);
      for (int i = 0; i < n; i++) begin
         bit ok = 0;
         while ($urandom_range(99) < stall) begin
            bus.ld_valid  = 0;
            bus.ld_data   = 8'($urandom);
            bus.req_valid = 1'($urandom);
            bus.req_addr  = 2'($urandom);
            bus.req_len   = 6'($urandom);
            @(negedge clk);
         end
         bus.req_valid = 0;
         bus.ld_valid = 1; bus.ld_data = pay[i];
         for (int g = 0; g < 100 && !ok; g++) begin
            @(posedge clk);
            if (bus.ld_ready) ok = 1;
         end
         if (!ok) chk("load_timeout", 0, 1);
         @(negedge clk);
         bus.ld_valid = 0;
      end
   endtask

   task automatic wait_pos(input int p);
      bit ok = 0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk);
         if (m_mode == 2 && m_pos == p) ok = 1;
      end
      if (!ok) chk("wait_pos_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         if (m_mode == 0 && bus.req_ready) ok = 1;
      end
      if (!ok) chk("idle_timeout", 0, 1);
   endtask

   task automatic run_pkt(input logic [1:0] a, input logic [5:0] n, input int stall,
                          input bit hold, output logic [7:0] hdr_o, output logic [7:0] par_o);
      int start, d0;
      logic [7:0] p;
      start = got.size(); d0 = done_cnt;
      send_req(a, n);
      load(int'(n), stall);
      if (hold) begin
         wait_pos(6);
         hold_until = cyc + 3;
         wait_pos(int'(n) + 1);
         hold_until = cyc + 3;
      end
      wait_idle();
      chk("pkt_bytes", got.size() - start, int'(n) + 1);
      hdr_o = 8'h00;
      if (got.size() - start == int'(n) + 1) begin
         hdr_o = got[start];
         chk("header", got[start], {n, a});
         for (int i = 0; i < int'(n); i++) chk("payload", got[start + 1 + i], pay[i]);
      end
      p = {n, a};
      for (int i = 0; i < int'(n); i++) p ^= pay[i];
      par_o = got_par;
      chk("parity", got_par, p);
      chk("done_pulses", done_cnt - d0, 1);
   endtask

   task automatic bad_req(input logic [1:0] a, input logic [5:0] n);
      int e0, g0;
      e0 = err_cnt; g0 = got.size();
      send_req(a, n);
      repeat (3) @(negedge clk);
      chk("req_err_pulses", err_cnt - e0, 1);
      chk("bad_req_no_bytes", got.size() - g0, 0);
   endtask

   logic [7:0] h, pr;

   initial begin
      rst = 1;
      bus.req_valid = 0; bus.req_addr = 0; bus.req_len = 0;
      bus.ld_valid = 0; bus.ld_data = 0; bus.busy = 0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_pkt_valid", bus.pkt_valid, 0);
      chk("rst_data_out",  bus.data_out, 0);
      chk("rst_tx_active", bus.tx_active, 0);
      chk("rst_ld_ready",  bus.ld_ready, 0);
      chk_en = 1;
      @(negedge clk) rst = 0;
      @(posedge clk) #1;
      chk("req_ready_after_rst", bus.req_ready, 1);

      // addr 01, len 14, no back-pressure
      for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
      run_pkt(2'b01, 6'd14, 0, 0, h, pr);
      chk("hdr_lit_39", h, 8'h39);
      chk("valid_run_15", last_run, 15);

      // back-pressure on payload byte 5 and on parity
      for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
      run_pkt(2'b10, 6'd10, 0, 1, h, pr);

      // invalid requests
      bad_req(2'b11, 6'd5);
      bad_req(2'b00, 6'd0);

      // boundary lengths
      for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
      run_pkt(2'b10, 6'd63, 20, 0, h, pr);
      chk("hdr_lit_FE", h, 8'hFE);
      chk("valid_run_64", last_run, 64);
      pay[0] = 8'hA5;
      run_pkt(2'b00, 6'd1, 0, 0, h, pr);
      chk("hdr_lit_04", h, 8'h04);
      chk("par_lit_A1", pr, 8'hA1);

      // reset in the middle of the payload
      for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
      send_req(2'b01, 6'd12);
      load(12, 0);
      wait_pos(8);
      rst = 1;
      @(posedge clk) #1;
      chk("midrst_pkt_valid", bus.pkt_valid, 0);
      chk("midrst_data_out",  bus.data_out, 0);
      chk("midrst_tx_active", bus.tx_active, 0);
      @(negedge clk) rst = 0;
      for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
      run_pkt(2'b00, 6'd3, 0, 0, h, pr);

      // randomized traffic with back-pressure and load stalls
      busy_pct = 30;
      for (int k = 0; k < 10; k++) begin
         if ($urandom_range(4) == 0) begin
            if ($urandom_range(1) == 0) bad_req(2'b11, 6'($urandom_range(1, 63)));
            else bad_req(2'($urandom_range(2)), 6'd0);
         end else begin
            for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
            run_pkt(2'($urandom_range(2)), 6'($urandom_range(1, 63)), 30, 0, h, pr);
         end
      end
      busy_pct = 0;
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Synthesizable packet source for the router input port. It accepts a transfer request (destination address plus payload length) and buffers the payload bytes. It then serializes the packet onto the router's `pkt_valid`/`data_in` interface as a header byte, the payload bytes and a parity byte, honouring the router's `busy` back-pressure. It sits upstream of `router_top` and replaces the bench-driven packet generation in system-level builds.

## Interface
- `MAX_LEN`, 63: maximum payload bytes; the buffer depth is 64.
- `IFG`, 2: idle cycles inserted after each parity byte.
- `clock`  in  1: single clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: a transfer request is present.
- `req_ready`  out  1: high only in IDLE.
- `req_addr`  in  2: destination port; 2'b11 is invalid.
- `req_len`  in  6: payload length, 1..63; 0 is invalid.
- `ld_valid`  in  1: a payload byte is present.
- `ld_data`  in  8: payload byte.
- `ld_ready`  out  1: high only in LOAD.
- `busy`  in  1: router back-pressure.
- `pkt_valid`  out  1: drives the router `pkt_valid`.
- `data_out`  out  8: drives the router `data_in`.
- `tx_active`  out  1: high in every state except IDLE.
- `pkt_done`  out  1: one-cycle pulse when the parity byte is consumed.
- `req_err`  out  1: one-cycle pulse when a request is rejected.

## Operation
- States: IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP.
- IDLE → LOAD: on `req_valid & req_ready` with a valid address and length. Latch `len` and `addr`; set `hdr = {req_len, req_addr}`; set `parity = hdr`; clear `cnt`.
- Invalid request (`req_addr == 2'b11` or `req_len == 0`): `req_err` pulses on the next cycle and the FSM stays in IDLE.
- LOAD: each `ld_valid & ld_ready` writes `buf[cnt]`, XORs the byte into `parity` and increments `cnt`. When the byte with `cnt == len-1` is accepted, go to HEADER.
- Consume rule: the byte on `data_out` is consumed at a rising edge only if `busy == 0` is sampled at that edge. Otherwise the byte and `pkt_valid` are held unchanged.
- HEADER: `pkt_valid = 1`, `data_out = hdr`. On consume, clear `idx` and go to PAYLOAD.
- PAYLOAD: `pkt_valid = 1`, `data_out = buf[idx]`. On consume, increment `idx`. After consuming `idx == len-1`, go to PARITY.
- PARITY: `pkt_valid = 0`, `data_out = parity`, where parity is the XOR of the header and all payload bytes. On consume, pulse `pkt_done` and go to GAP.
- GAP: `pkt_valid = 0`, `data_out = 0` for `IFG` cycles, then IDLE.
- Ignored inputs: `req_valid` outside IDLE (`req_ready = 0`) and `ld_valid` outside LOAD.
- Arithmetic: `cnt` and `idx` are 6 bits and never wrap past `len-1`. Parity is an 8-bit XOR.

## Timing
- All outputs are registered.
- Reset values: `req_ready = 0` during reset and 1 from the first cycle after reset; `ld_ready = 0`; `pkt_valid = 0`; `data_out = 8'h00`; `tx_active = 0`; `pkt_done = 0`; `req_err = 0`. State = IDLE, counters = 0.
- Request accepted at edge T: `ld_ready = 1` from T+1.
- Last payload byte loaded at edge L: header on `data_out` from L+1.
- With `busy` held low, a packet with `len = N` shows `pkt_valid` high for N+1 consecutive cycles, then one parity cycle.
- `pkt_done` is high in the cycle after the parity consume edge. `req_ready` rises `IFG + 1` cycles after that edge.
- A `busy` rising edge during PARITY holds the parity byte on `data_out` with `pkt_valid = 0`.
- Reset mid-packet: from the next cycle, outputs take their reset values and the packet is abandoned, not resumed. Buffer contents are don't-care.
- An LOAD-phase stall, i.e. `ld_valid` low, never touches the router interface, because `pkt_valid` stays 0 until HEADER.

## Structure
- Package `router_pkg`:
  - `ADDR_W = 2`, `LEN_W = 6`, `DATA_W = 8`
  - `ADDR_INVALID = 2'b11`
  - `tx_state_t` enum
  - header pack/unpack function `{len, addr}`; shared with the router decode logic.
- Sub-module `router_tx_buf`: 64x8 register array with one synchronous write port and one asynchronous read port. It is instantiated once.
- The FSM, counters and parity accumulator live in `router_pkt_tx`.

## Test plan
- Reset: assert `reset` for 2 cycles → all outputs 0, then `req_ready = 1` one cycle after release.
- Addr 01, len 14, `busy` always 0:
  - header 0x39, then 14 bytes in order, then the parity byte equal to the XOR of all 15 bytes with `pkt_valid = 0`.
  - `pkt_done` pulses once; `req_ready` returns 3 cycles after the parity consume edge.
- Back-pressure: raise `busy` for 3 cycles while payload byte 5 is presented → byte 5 is held for 4 cycles, with no loss or duplication. The same `busy` pattern during PARITY holds the parity byte.
- Invalid requests:
  - addr 11, len 5 → one `req_err` pulse, no `pkt_valid`, `ld_ready` stays 0.
  - addr 00, len 0 → same response.
- Boundary lengths:
  - addr 10, len 63 → header 0xFE, 63 payload bytes, correct parity, no index wrap.
  - addr 00, len 1 → header 0x04, 1 byte, parity = 0x04 ^ byte.
- Reset at payload byte 7 → next cycle `pkt_valid = 0`, `data_out = 0`, state IDLE. A following len-3 request completes correctly.
